fifo_word_packer: RTL
=====================

// Module: fifo_word_packer
// PURPOSE
//  Read-side consumer of async_fifo. Pops DSIZE-bit entries and packs LANES of them into one wide word.
//  Presents the word on a valid/ready output. A partial word is flushed, with lane-keep mask, after TIMEOUT idle cycles.
//  Sits entirely in the rclk domain, directly on the FIFO read port (rdata/rinc/rempty).
// PARAMETERS
//  DSIZE    8   width of one FIFO entry (matches async_fifo DSIZE)
//  LANES    4   entries per output word; power of 2, >=2
//  TIMEOUT  16  idle rclk cycles with a partial word before flush; >=1
// PORTS
//  rclk       in   1              read-domain clock
//  rrst_n     in   1              asynchronous, active-low reset
//  rdata      in   DSIZE          FIFO head entry; valid whenever rempty=0 (first-word fall-through)
//  rempty     in   1              FIFO empty flag
//  rinc       out  1              pop strobe to FIFO
//  out_data   out  DSIZE*LANES    packed word; first-popped entry in lane 0 (LSBs)
//  out_keep   out  LANES          lane-valid mask; all-ones for a full word
//  out_valid  out  1              out_data/out_keep valid
//  out_ready  in   1              consumer accepts when out_valid&&out_ready
//  words_sent out  16             count of accepted words; wraps at 2^16
// BEHAVIOUR
//  Clock, reset and one-cycle ordering
//  - One clock, rclk; reset rrst_n is asynchronous, active-low.
//  - Reset values: out_valid=0, out_data=0, out_keep=0, words_sent=0. Internals: lane count cnt=0, idle=0, flush_pend=0.
//  - rinc is combinational and is 0 while rrst_n=0.
//  Pop rules
//  - rinc = !rempty && !flush_pend && !(acc_full && out_busy).
//  - rinc is never asserted while rempty=1.
//  - out_busy = out_valid && !out_ready.
//  - On a pop, rdata is captured into acc lane[cnt] and cnt increments. Pop-to-out_valid latency is 1 cycle for the last lane.
//  Word emission (out register free means !out_busy)
//  - Full word: when cnt reaches LANES and out is free, load out_data and out_keep='1, set out_valid, cnt=0.
//  - The last-lane pop and the load can occur in the same cycle when out is free, giving 1 word per LANES cycles at full rate.
//  - If acc is full and out is busy, popping stalls until out_ready.
//  Timeout flush
//  - idle increments each cycle with 0<cnt<LANES and no pop; it clears on any pop or emit.
//  - When idle==TIMEOUT-1, set flush_pend and stop popping.
//  - While flush_pend=1 and out is free: load the partial word with out_keep=(1<<cnt)-1, zero the unused lanes, cnt=0, clear flush_pend.
//  - A pop that completes a word in the same cycle the timeout would fire emits a full word; the timeout is cancelled.
//  - cnt=0 never times out. An empty flush is never emitted.
//  Output handshake
//  - out_data and out_keep hold stable while out_valid && !out_ready.
//  - An accept and a new load in the same cycle keep out_valid=1 (back-to-back).
//  - words_sent increments on each accept.
//  Arithmetic
//  - cnt is $clog2(LANES)+1 bits; idle is $clog2(TIMEOUT)+1 bits, saturating.
//  Reset mid-operation
//  - A partial accumulator is discarded and out_valid drops immediately. No pop occurs during reset.
// STRUCTURE
//  - fifo_pkg: DSIZE, LANES and TIMEOUT defaults; the lane-index typedef; state enum {FILL, FLUSH_PEND}.
//  - One sub-module, pack_idle_timer: idle counter, flush_pend generation and cancel-on-pop.
//  - Accumulator, output register and words_sent are inline.
// TESTING (C reference model via DPI mirrors the pack/flush rules; bench compares every accept)
//  - Push 0x10..0x17 with out_ready=1 -> words 0x13121110 and 0x17161514, keep=4'hF, words_sent=2.
//  - Push 0xA0,0xA1 then idle -> after 16 idle cycles, out_data=0x0000A1A0, keep=4'h3.
//  - Push 12 entries with out_ready=0 -> exactly 8 pops, then rinc=0 with rempty=0.
//    Raise out_ready -> 3 words in order, no loss.
//  - Third entry popped exactly on the idle cycle 15 boundary, fourth arrives next cycle -> one full word, no partial flush.
//  - rrst_n low while cnt=2 and out_valid=1 -> out_valid=0 in the same cycle.
//    After release, the next 4 entries form a clean word with keep=4'hF.
//  - rempty held at 1 for 100 cycles with random out_ready -> rinc never asserted, out_valid stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, lane index type and packer state enum
package fifo_pkg;

    localparam int DSIZE_DEF   = 8;
    localparam int LANES_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef logic [$clog2(LANES_DEF)-1:0] lane_idx_t;

    typedef enum logic {
        FILL       = 1'b0,
        FLUSH_PEND = 1'b1
    } pack_state_e;

endpackage

// File: rtl/pack_idle_timer.sv
// rtl/pack_idle_timer.sv - idle counter that requests a flush of a stalled partial word
module pack_idle_timer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int IW      = $clog2(TIMEOUT) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic partial,
    input  logic pop,
    input  logic emit,
    output logic flush_pend
);

    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    pack_state_e   state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            FILL: begin
                // A pop landing on the firing cycle wins: the timer restarts instead.
                if (pop || emit || !partial) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = FLUSH_PEND;
                    idle_d  = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + IW'(1);
                end
            end
            FLUSH_PEND: begin
                idle_d = '0;
                if (emit) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                idle_d  = '0;
            end
        endcase
    end

    assign flush_pend = (state_q == FLUSH_PEND);

endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs LANES FIFO entries into one wide word with idle-timeout flush
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE   = DSIZE_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    output logic [DSIZE*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            words_sent
);

    localparam int              LW       = $clog2(LANES);
    localparam int              CW       = LW + 1;
    localparam logic [CW-1:0]   CNT_FULL = CW'(LANES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(LANES - 1);

    logic [LANES-1:0][DSIZE-1:0] acc_q, acc_d;
    logic [LANES-1:0][DSIZE-1:0] out_data_q, out_data_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [LANES-1:0]            out_keep_q, out_keep_d;
    logic                        out_valid_q, out_valid_d;
    logic [15:0]                 words_sent_q, words_sent_d;

    logic acc_full, out_busy, out_free, pop, accept;
    logic emit_full, emit_flush, flush_pend;

    assign acc_full = (cnt_q == CNT_FULL);
    assign out_busy = out_valid_q && !out_ready;
    assign out_free = !out_busy;
    assign accept   = out_valid_q && out_ready;

    assign rinc = rrst_n && !rempty && !flush_pend && !(acc_full && out_busy);
    assign pop  = rinc;

    // The last-lane pop bypasses the accumulator so a full word loads on the same edge.
    assign emit_full  = out_free && (acc_full || (pop && cnt_q == CNT_LAST));
    assign emit_flush = out_free && flush_pend && (cnt_q != '0);

    pack_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk        (rclk),
        .rst_n      (rrst_n),
        .partial    ((cnt_q != '0) && !acc_full),
        .pop        (pop),
        .emit       (emit_full || emit_flush),
        .flush_pend (flush_pend)
    );

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            words_sent_q <= '0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
            words_sent_q <= words_sent_d;
        end
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_valid_d  = out_valid_q;
        words_sent_d = words_sent_q;

        if (accept) begin
            out_valid_d  = 1'b0;
            words_sent_d = words_sent_q + 16'd1;
        end

        // With a full accumulator the low index bits wrap to lane 0 of the next word.
        if (pop) begin
            acc_d[cnt_q[LW-1:0]] = rdata;
        end

        if (emit_full) begin
            out_data_d  = acc_full ? acc_q : acc_d;
            out_keep_d  = '1;
            out_valid_d = 1'b1;
            cnt_d       = (acc_full && pop) ? CW'(1) : '0;
        end else if (emit_flush) begin
            for (int i = 0; i < LANES; i++) begin
                out_data_d[i] = (CW'(i) < cnt_q) ? acc_q[i] : '0;
                out_keep_d[i] = (CW'(i) < cnt_q);
            end
            out_valid_d = 1'b1;
            cnt_d       = '0;
        end else if (pop) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign out_data   = out_data_q;
    assign out_keep   = out_keep_q;
    assign out_valid  = out_valid_q;
    assign words_sent = words_sent_q;

endmodule
